// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register file with busy scoreboard and optional bypass
module regfile_2r1w #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 16,
  parameter int               AW        = 4,
  parameter bit               R0_ZERO   = 1'b0,
  parameter bit               BYPASS    = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [AW-1:0]          raddrA,
  output logic [WIDTH-1:0]       rdataA,
  input  logic [AW-1:0]          raddrB,
  output logic [WIDTH-1:0]       rdataB,
  input  logic                   lockEn,
  input  logic [AW-1:0]          lockAddr,
  output logic                   busyA,
  output logic                   busyB,
  output logic [DEPTH-1:0]       busyVec,
  output logic [DEPTH*WIDTH-1:0] regsFlat
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [WIDTH-1:0] view [DEPTH];
  logic [DEPTH-1:0] bview;
  logic [DEPTH-1:0] fwd;

  function automatic logic is_zero_reg(input int i);
    return R0_ZERO && (i == 0);
  endfunction

  // Lock is applied after the write so a same-cycle new producer leaves the register busy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        regs[i] <= is_zero_reg(i) ? '0 : RESET_VAL;
        busy[i] <= 1'b0;
      end else if (!is_zero_reg(i)) begin
        if (we && waddr == AW'(i)) begin
          regs[i] <= wdata;
          busy[i] <= 1'b0;
        end
        if (lockEn && lockAddr == AW'(i)) begin
          busy[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      view[i]  = is_zero_reg(i) ? '0 : regs[i];
      bview[i] = !is_zero_reg(i) && busy[i];
      fwd[i]   = BYPASS && we && (waddr == AW'(i)) && !is_zero_reg(i);
    end
  end

  // Addresses at or beyond DEPTH match no register and so read as zero / not busy.
  always_comb begin
    rdataA = '0;
    busyA  = 1'b0;
    rdataB = '0;
    busyB  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddrA == AW'(i)) begin
        rdataA = fwd[i] ? wdata : view[i];
        busyA  = !fwd[i] && bview[i];
      end
      if (raddrB == AW'(i)) begin
        rdataB = fwd[i] ? wdata : view[i];
        busyB  = !fwd[i] && bview[i];
      end
    end
  end

  always_comb begin
    regsFlat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      regsFlat[i*WIDTH +: WIDTH] = view[i];
    end
  end

  assign busyVec = bview;

endmodule
